ram_stream_reader: RTL and testbench
====================================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width of RAM data and stream data.
REQ-002 Parameter ADDRESS_WIDTH, default 12, RAM address width; addressable depth = 2^ADDRESS_WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begin a burst; sampled only in IDLE.
REQ-006 base_addr  input  ADDRESS_WIDTH  first RAM address of the burst; captured with start.
REQ-007 length  input  ADDRESS_WIDTH+1  word count, 0..2^ADDRESS_WIDTH; captured with start.
REQ-008 busy  output  1  high from the edge accepting start until the done pulse.
REQ-009 done  output  1  one-cycle pulse after the last beat is accepted, or after a zero-length start.
REQ-010 mem_addr  output  ADDRESS_WIDTH  registered address driven to the RAM port.
REQ-011 mem_wEn  output  1  RAM write enable; constant 0.
REQ-012 mem_dataOut  input  DATA_WIDTH  RAM registered read data (1-cycle read latency).
REQ-013 out_data  output  DATA_WIDTH  stream data.
REQ-014 out_valid  output  1  stream data valid.
REQ-015 out_ready  input  1  sink ready; a beat transfers when out_valid && out_ready at a rising edge.
REQ-016 out_last  output  1  high with the final beat of a burst.

Function
REQ-017 FSM states: IDLE, READ (reads remaining), DRAIN (all reads issued, beats outstanding), DONE (one cycle, done=1, then IDLE).
REQ-018 IDLE + start=1: capture base_addr/length; length=0 -> DONE, else READ.
REQ-019 A read is issued by registering mem_addr = next address and setting an internal in-flight flag; data is captured from mem_dataOut exactly one edge later, only when the flag is set.
REQ-020 Output buffer: 2-entry FIFO; a read is issued only if (entries + in-flight - pop-this-cycle) < 2; no overflow, no beat loss under any out_ready pattern.
REQ-021 With out_ready held high, throughput 1 beat/cycle; first out_valid rises after the second rising edge following the start-accepting edge.
REQ-022 Addresses increment by 1 per read and wrap modulo 2^ADDRESS_WIDTH.
REQ-023 out_data/out_valid/out_last stable while out_valid && !out_ready.
REQ-024 Beats emitted in address order; out_last asserted only on beat number length.
REQ-025 READ -> DRAIN when the length-th read issues; DRAIN -> DONE on the edge accepting the last beat.
REQ-026 start while busy: ignored, no effect on the current burst.
REQ-027 length = 2^ADDRESS_WIDTH: reads every location once, last address = base_addr-1 (mod depth).

Reset
REQ-028 reset_n low, at any time including mid-burst: FSM=IDLE, FIFO emptied, in-flight cleared, busy=0, done=0, out_valid=0, out_last=0, out_data=0, mem_addr=0, mem_wEn=0; no beat emitted after release until a new start.

Configuration
REQ-029 Macro RAM_STREAM_READER_CHECKSUM_EN defined: output checksum [DATA_WIDTH-1:0] = modulo-2^DATA_WIDTH sum of all accepted beats of the current burst; cleared to 0 on start acceptance and on reset; final value valid when done pulses.
REQ-030 Macro undefined: checksum port and its logic absent; all other behaviour identical.

Verification
REQ-031 RAM[i]=i+100, start base=5 length=4, out_ready=1 -> beats 105,106,107,108 on consecutive cycles, out_last on 108, done one cycle later.
REQ-032 base=4094 length=4 (ADDRESS_WIDTH=12) -> beats from addresses 4094,4095,0,1.
REQ-033 length=3, out_ready toggling 1,0,0,1,0,1 -> exactly 3 beats in order, data held stable while stalled, no duplicates.
REQ-034 length=0 -> no out_valid, done pulses on the cycle after start; start pulsed while busy -> ignored, original burst completes unchanged.
REQ-035 reset_n low during beat 2 of length=8 -> all outputs zero immediately; after release, no beats until new start; new burst base=0 length=2 behaves normally.
REQ-036 With RAM_STREAM_READER_CHECKSUM_EN, RAM[0..3]=1,2,3,0xFFFFFFFF, base=0 length=4 -> checksum=0x00000005 at done.

Source files
------------

// File: rtl/ram_stream_reader.sv
// Burst reader: streams length words from a 1-cycle-latency RAM, starting at base_addr, onto a valid/ready interface.
// Optional macro RAM_STREAM_READER_CHECKSUM_EN adds a running modulo-2^DATA_WIDTH sum of accepted beats.
module ram_stream_reader #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 12
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] base_addr,
   input  logic [ADDRESS_WIDTH:0]   length,
   output logic                     busy,
   output logic                     done,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic                     mem_wEn,
   input  logic [DATA_WIDTH-1:0]    mem_dataOut,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
`ifdef RAM_STREAM_READER_CHECKSUM_EN
   output logic                     out_last,
   output logic [DATA_WIDTH-1:0]    checksum
`else
   output logic                     out_last
`endif
);

   localparam int unsigned LEN_W = ADDRESS_WIDTH + 1;
   localparam int unsigned OCC_W = 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                   r_state;
   logic [LEN_W-1:0]         r_remaining;
   logic [ADDRESS_WIDTH-1:0] r_next_addr;
   logic [ADDRESS_WIDTH-1:0] r_mem_addr;
   logic                     r_inflight;
   logic                     r_inflight_last;
   logic                     r_busy;
   logic                     r_done;
   // Two-entry buffer: head drives the stream outputs directly, skid holds the second word.
   logic [DATA_WIDTH-1:0]    r_out_data;
   logic                     r_out_valid;
   logic                     r_out_last;
   logic [DATA_WIDTH-1:0]    r_skid_data;
   logic                     r_skid_valid;
   logic                     r_skid_last;
`ifdef RAM_STREAM_READER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0]    r_checksum;
`endif

   logic                     w_pop;
   logic [OCC_W-1:0]         w_occ;
   logic                     w_issue;
   logic                     w_last_issue;

   // Buffer occupancy plus the word in flight, net of this cycle's pop, never exceeds one before an issue.
   assign w_pop        = r_out_valid && out_ready;
   assign w_occ        = OCC_W'(r_out_valid) + OCC_W'(r_skid_valid) + OCC_W'(r_inflight) - OCC_W'(w_pop);
   assign w_issue      = (r_state == S_READ) && (w_occ < OCC_W'(2));
   assign w_last_issue = (r_remaining == LEN_W'(1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state         <= S_IDLE;
         r_remaining     <= '0;
         r_next_addr     <= '0;
         r_mem_addr      <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_out_data      <= '0;
         r_out_valid     <= 1'b0;
         r_out_last      <= 1'b0;
         r_skid_data     <= '0;
         r_skid_valid    <= 1'b0;
         r_skid_last     <= 1'b0;
`ifdef RAM_STREAM_READER_CHECKSUM_EN
         r_checksum      <= '0;
`endif
      end else begin
         r_done     <= 1'b0;
         r_inflight <= w_issue;

         if (w_issue) begin
            r_mem_addr      <= r_next_addr;
            r_next_addr     <= r_next_addr + ADDRESS_WIDTH'(1);
            r_inflight_last <= w_last_issue;
            r_remaining     <= r_remaining - LEN_W'(1);
         end

         // Read data returns one edge after issue and is pushed behind whatever is still buffered.
         if (!r_out_valid || w_pop) begin
            if (r_skid_valid) begin
               r_out_data   <= r_skid_data;
               r_out_last   <= r_skid_last;
               r_out_valid  <= 1'b1;
               r_skid_valid <= r_inflight;
               if (r_inflight) begin
                  r_skid_data <= mem_dataOut;
                  r_skid_last <= r_inflight_last;
               end
            end else if (r_inflight) begin
               r_out_data  <= mem_dataOut;
               r_out_last  <= r_inflight_last;
               r_out_valid <= 1'b1;
            end else begin
               r_out_valid <= 1'b0;
               r_out_last  <= 1'b0;
            end
         end else if (r_inflight) begin
            r_skid_data  <= mem_dataOut;
            r_skid_last  <= r_inflight_last;
            r_skid_valid <= 1'b1;
         end

`ifdef RAM_STREAM_READER_CHECKSUM_EN
         if (w_pop) begin
            r_checksum <= r_checksum + r_out_data;
         end
`endif

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_next_addr <= base_addr;
                  r_remaining <= length;
`ifdef RAM_STREAM_READER_CHECKSUM_EN
                  r_checksum  <= '0;
`endif
                  if (length == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_READ;
                     r_busy  <= 1'b1;
                  end
               end
            end
            S_READ: begin
               if (w_issue && w_last_issue) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_pop && r_out_last) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign mem_addr  = r_mem_addr;
   assign mem_wEn   = 1'b0;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
`ifdef RAM_STREAM_READER_CHECKSUM_EN
   assign checksum  = r_checksum;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader; RAM[i] = i + 100 unless a test overrides it.
module tb_ram_stream_reader;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 12;
   localparam int          DEPTH = 4096;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic          busy;
   logic          done;
   logic [AW-1:0] mem_addr;
   logic          mem_wEn;
   logic [DW-1:0] mem_dataOut;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
`ifdef RAM_STREAM_READER_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   logic [DW-1:0] tb_ram [DEPTH];
   int            n_checks = 0;
   int            n_fail   = 0;

   ram_stream_reader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .base_addr   (base_addr),
      .length      (length),
      .busy        (busy),
      .done        (done),
      .mem_addr    (mem_addr),
      .mem_wEn     (mem_wEn),
      .mem_dataOut (mem_dataOut),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
`ifdef RAM_STREAM_READER_CHECKSUM_EN
      .out_last    (out_last),
      .checksum    (checksum)
`else
      .out_last    (out_last)
`endif
   );

   always #5 clk = ~clk;

   // RAM address register is mem_addr itself, so read data follows it by one edge.
   assign mem_dataOut = tb_ram[mem_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Runs one burst with an LSB-first out_ready pattern (applied once data appears), optional stray start at cycle poke.
   task automatic run_burst(input int base, input int len, input logic [7:0] pat, input int npat, input int poke);
      int            nb;
      int            k;
      logic          seen;
      logic          stalled;
      logic          got_done;
      logic [DW-1:0] held_d;
      logic          held_l;
      logic [DW-1:0] exp_d;
      nb       = 0;
      k        = 0;
      seen     = 1'b0;
      stalled  = 1'b0;
      got_done = 1'b0;
      held_d   = '0;
      held_l   = 1'b0;
      base_addr = AW'(base);
      length    = (AW+1)'(len);
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int cyc = 0; cyc < len + 50; cyc++) begin
         if (done) begin
            got_done = 1'b1;
            break;
         end
         if (stalled) begin
            check("stall_valid", 64'(out_valid), 64'(1));
            check("stall_data", 64'(out_data), 64'(held_d));
            check("stall_last", 64'(out_last), 64'(held_l));
         end
         if (out_valid) seen = 1'b1;
         out_ready = (k < npat) ? pat[0] : 1'b1;
         if (seen && k < npat) begin
            pat = pat >> 1;
            k++;
         end
         start = (cyc == poke);
         if (cyc == poke) begin
            base_addr = '0;
            length    = (AW+1)'(1);
         end
         if (out_valid && out_ready) begin
            exp_d = DW'(((base + nb) % DEPTH) + 100);
            check("beat_data", 64'(out_data), 64'(exp_d));
            check("beat_last", 64'(out_last), 64'(nb == len - 1));
            nb++;
         end
         stalled = out_valid && !out_ready;
         held_d  = out_data;
         held_l  = out_last;
         tick();
      end
      start     = 1'b0;
      out_ready = 1'b1;
      check("burst_done_seen", 64'(got_done), 64'(1));
      check("burst_beat_count", 64'(nb), 64'(len));
      tick();
      check("done_one_cycle", 64'(done), 64'(0));
   endtask

   initial begin
      reset_n   = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) tb_ram[i] = DW'(i + 100);
      tick();
      tick();

      // reset state
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_last", 64'(out_last), 64'(0));
      check("rst_data", 64'(out_data), 64'(0));
      check("rst_addr", 64'(mem_addr), 64'(0));
      check("rst_wen", 64'(mem_wEn), 64'(0));
      reset_n = 1'b1;
      tick();

      // base 5, length 4, ready high: exact cycle timing
      base_addr = AW'(5);
      length    = (AW+1)'(4);
      start     = 1'b1;
      tick();
      start = 1'b0;
      check("t1_busy", 64'(busy), 64'(1));
      check("t1_valid_e0", 64'(out_valid), 64'(0));
      tick();
      check("t1_addr_e1", 64'(mem_addr), 64'(5));
      check("t1_valid_e1", 64'(out_valid), 64'(0));
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t1_valid", 64'(out_valid), 64'(1));
         check("t1_data", 64'(out_data), 64'(105 + i));
         check("t1_last", 64'(out_last), 64'(i == 3));
      end
      tick();
      check("t1_valid_end", 64'(out_valid), 64'(0));
      check("t1_done", 64'(done), 64'(1));
      check("t1_busy_end", 64'(busy), 64'(0));
      tick();
      check("t1_done_low", 64'(done), 64'(0));
      check("t1_wen", 64'(mem_wEn), 64'(0));

      // address wrap at top of memory
      run_burst(4094, 4, 8'h00, 0, -1);

      // backpressure pattern 1,0,0,1,0,1
      run_burst(10, 3, 8'h29, 6, -1);

      // zero length
      base_addr = AW'(9);
      length    = '0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      check("z_done", 64'(done), 64'(1));
      check("z_valid", 64'(out_valid), 64'(0));
      tick();
      check("z_done_low", 64'(done), 64'(0));
      check("z_valid2", 64'(out_valid), 64'(0));

      // stray start while busy is ignored
      run_burst(20, 3, 8'h00, 0, 2);
      tick();
      check("poke_no_busy", 64'(busy), 64'(0));
      check("poke_no_valid", 64'(out_valid), 64'(0));

      // reset during beat 2 of an 8-word burst
      base_addr = '0;
      length    = (AW+1)'(8);
      start     = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      check("mr_beat2", 64'(out_data), 64'(101));
      reset_n = 1'b0;
      #1;
      check("mr_busy", 64'(busy), 64'(0));
      check("mr_valid", 64'(out_valid), 64'(0));
      check("mr_last", 64'(out_last), 64'(0));
      check("mr_data", 64'(out_data), 64'(0));
      check("mr_addr", 64'(mem_addr), 64'(0));
      check("mr_done", 64'(done), 64'(0));
      tick();
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("mr_quiet_valid", 64'(out_valid), 64'(0));
         check("mr_quiet_busy", 64'(busy), 64'(0));
      end
      run_burst(0, 2, 8'h00, 0, -1);

      // full depth from base 7: last beat comes from address 6
      run_burst(7, DEPTH, 8'h00, 0, -1);

`ifdef RAM_STREAM_READER_CHECKSUM_EN
      begin
         logic got;
         got = 1'b0;
         tb_ram[0] = 32'h1;
         tb_ram[1] = 32'h2;
         tb_ram[2] = 32'h3;
         tb_ram[3] = 32'hFFFF_FFFF;
         base_addr = '0;
         length    = (AW+1)'(4);
         start     = 1'b1;
         tick();
         start = 1'b0;
         check("cs_cleared", 64'(checksum), 64'(0));
         for (int i = 0; i < 30; i++) begin
            if (done) begin
               got = 1'b1;
               break;
            end
            tick();
         end
         check("cs_done_seen", 64'(got), 64'(1));
         check("cs_value", 64'(checksum), 64'(32'h5));
         tick();
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
